// File: rtl/tone_pkg.sv
// Shared definitions for the multi-channel tone generator.
//   - word offsets of the four per-channel registers
//   - bit positions inside the global control register
//   - channel configuration record used by the top-level read mux
package tone_pkg;

    localparam int OFF_CTRL   = 0;
    localparam int OFF_PERIOD = 1;
    localparam int OFF_DUTY   = 2;
    localparam int OFF_STATUS = 3;

    localparam int GCTRL_RESTART_BIT = 0;
    localparam int GCTRL_MUTE_BIT    = 1;

    // Register readback width; channel fields are zero-extended into it.
    localparam int CFG_W = 32;

    typedef struct packed {
        logic             enable;
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] duty;
    } chan_cfg_t;

endpackage

// File: rtl/tone_channel.sv
// One tone channel: shadow and active period/duty registers, free-running
// counter, wrap/reload logic and the square-wave output bit.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   restart_i      global phase-align pulse (cnt=0, reload active)
//   mute_i         global mute, gates only the output bit
//   wr_*_i         write strobes for CTRL / PERIOD / DUTY
//   wdata_i        write data (low CNT_W bits of the bus)
//   en_o           enable bit readback
//   period_o       shadow period readback
//   duty_o         shadow duty readback
//   cnt_o          live counter
//   tone_o         tone output, combinational from flops
module tone_channel #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart_i,
    input  logic             mute_i,
    input  logic             wr_ctrl_i,
    input  logic             wr_period_i,
    input  logic             wr_duty_i,
    input  logic [CNT_W-1:0] wdata_i,
    output logic             en_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] duty_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tone_o
);

    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic             en_q, en_d;
    logic [CNT_W-1:0] per_sh_q, per_sh_d;
    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic [CNT_W-1:0] per_act_q, per_act_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run;
    logic             wrap;

    always_comb begin
        run  = en_q && (per_act_q >= MIN_PERIOD);
        wrap = run && (cnt_q == per_act_q - ONE);

        en_d      = en_q;
        per_sh_d  = per_sh_q;
        duty_sh_d = duty_sh_q;
        if (wr_ctrl_i)   en_d      = wdata_i[0];
        if (wr_period_i) per_sh_d  = wdata_i;
        if (wr_duty_i)   duty_sh_d = wdata_i;

        cnt_d      = cnt_q + ONE;
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;
        // Active values come from the pre-edge shadow, so a write landing on
        // a reload edge is only picked up at the following reload. A stopped
        // channel (disabled or period < 2) reloads every cycle.
        if (restart_i || !run || wrap) begin
            cnt_d      = '0;
            per_act_d  = per_sh_q;
            duty_act_d = duty_sh_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q       <= 1'b0;
            per_sh_q   <= '0;
            duty_sh_q  <= '0;
            per_act_q  <= '0;
            duty_act_q <= '0;
            cnt_q      <= '0;
        end else begin
            en_q       <= en_d;
            per_sh_q   <= per_sh_d;
            duty_sh_q  <= duty_sh_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            cnt_q      <= cnt_d;
        end
    end

    assign en_o     = en_q;
    assign period_o = per_sh_q;
    assign duty_o   = duty_sh_q;
    assign cnt_o    = cnt_q;
    // duty >= period gives constant high, duty == 0 constant low.
    assign tone_o   = run && !mute_i && (cnt_q < duty_act_q);

endmodule

// File: rtl/multi_tone_gen.sv
// Memory-mapped multi-channel square-wave/PWM tone generator.
// Word map: ch*4+{0 CTRL,1 PERIOD,2 DUTY,3 STATUS}, NUM_CH*4 GCTRL
// (bit0 restart pulse, bit1 mute). Unmapped reads return 0.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   we, re      register write / read strobes
//   addr        word address
//   wdata       write data
//   rdata       registered read data, valid the cycle after re
//   tone_out    per-channel tone outputs
//   mix_level   number of tone_out bits currently high
module multi_tone_gen
    import tone_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24,
    parameter int ADDR_W = $clog2(NUM_CH) + 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic                       re,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata,
    output logic [NUM_CH-1:0]          tone_out,
    output logic [$clog2(NUM_CH+1)-1:0] mix_level
);

    localparam int MIX_W      = $clog2(NUM_CH + 1);
    localparam int GCTRL_ADDR = NUM_CH * 4;

    logic              ch_hit;
    logic              g_hit;
    logic [ADDR_W-3:0] ch_sel;
    logic [1:0]        off;
    logic              restart;
    logic              mute_q, mute_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              wdata_unused;

    chan_cfg_t         cfg_a [NUM_CH];
    logic [CNT_W-1:0]  cnt_a [NUM_CH];

    assign ch_sel  = addr[ADDR_W-1:2];
    assign off     = addr[1:0];
    assign ch_hit  = int'(addr) < GCTRL_ADDR;
    assign g_hit   = int'(addr) == GCTRL_ADDR;
    assign restart = we && g_hit && wdata[GCTRL_RESTART_BIT];
    assign wdata_unused = ^wdata;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             wr_hit;
        logic             en_w;
        logic [CNT_W-1:0] per_w;
        logic [CNT_W-1:0] duty_w;

        assign wr_hit = we && ch_hit && (int'(ch_sel) == c);

        tone_channel #(.CNT_W(CNT_W)) u_ch (
            .clk         (clk),
            .rst         (rst),
            .restart_i   (restart),
            .mute_i      (mute_q),
            .wr_ctrl_i   (wr_hit && (int'(off) == OFF_CTRL)),
            .wr_period_i (wr_hit && (int'(off) == OFF_PERIOD)),
            .wr_duty_i   (wr_hit && (int'(off) == OFF_DUTY)),
            .wdata_i     (wdata[CNT_W-1:0]),
            .en_o        (en_w),
            .period_o    (per_w),
            .duty_o      (duty_w),
            .cnt_o       (cnt_a[c]),
            .tone_o      (tone_out[c])
        );

        assign cfg_a[c].enable = en_w;
        assign cfg_a[c].period = CFG_W'(per_w);
        assign cfg_a[c].duty   = CFG_W'(duty_w);
    end

    always_comb begin
        mute_d = mute_q;
        if (we && g_hit) mute_d = wdata[GCTRL_MUTE_BIT];

        rdata_d = rdata_q;
        if (re) begin
            rdata_d = '0;
            if (g_hit) rdata_d[GCTRL_MUTE_BIT] = mute_q;
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_hit && (int'(ch_sel) == c)) begin
                    case (int'(off))
                        OFF_CTRL:   rdata_d[0] = cfg_a[c].enable;
                        OFF_PERIOD: rdata_d    = cfg_a[c].period;
                        OFF_DUTY:   rdata_d    = cfg_a[c].duty;
                        default:    rdata_d    = 32'(cnt_a[c]);
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mute_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            mute_q  <= mute_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

    always_comb begin
        mix_level = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mix_level = mix_level + MIX_W'(tone_out[c]);
        end
    end

endmodule
